// File: rtl/ram_rmw_pkg.sv
// Shared definitions for the RAM read-modify-write master.
// Contents: RAM geometry constants, controller state enum and the latched
// request payload struct. No ports.
package ram_rmw_pkg;

  localparam int unsigned RAM_WORD_W                = 64;
  localparam int unsigned RAM_ADDR_W                = 36;
  localparam int unsigned RAM_BE_W                  = RAM_WORD_W / 8;
  localparam int unsigned RAM_LSB_W                 = 3;
  localparam int unsigned RAM_WIDX_W                = RAM_ADDR_W - RAM_LSB_W;
  localparam int unsigned RAM_MEMORY_SIZE_IN_DWORDS = 32768;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  // Request as held for the duration of one transaction (word index only,
  // the byte offset within the word is irrelevant to the RAM).
  typedef struct packed {
    logic                  write;
    logic [RAM_WIDX_W-1:0] widx;
    logic [RAM_WORD_W-1:0] wdata;
    logic [RAM_BE_W-1:0]   be;
  } req_t;

endpackage

// File: rtl/ram_rmw_master_if.sv
// Client request/response handshake plus RAM pin bundle.
// Modports:
//   master - the controller: takes req_*/rsp_ready/mem_data_out,
//            drives req_ready/rsp_*/mem_* towards client and RAM.
//   slave  - the environment (client + RAM): the mirror image.
interface ram_rmw_master_if;
  import ram_rmw_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [RAM_ADDR_W-1:0] req_addr;
  logic [RAM_WORD_W-1:0] req_wdata;
  logic [RAM_BE_W-1:0]   req_be;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [RAM_WORD_W-1:0] rsp_data;
  logic                  rsp_err;

  logic                  mem_clock_enable;
  logic [RAM_ADDR_W-1:0] mem_addr;
  logic                  mem_write_enab;
  logic [RAM_WORD_W-1:0] mem_data_in;
  logic [RAM_WORD_W-1:0] mem_data_out;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    input  rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output mem_clock_enable, mem_addr, mem_write_enab, mem_data_in
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    output rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  mem_clock_enable, mem_addr, mem_write_enab, mem_data_in
  );

endinterface

// File: rtl/ram_byte_merge.sv
// Combinational 8-lane byte merge: lanes with be=1 take new_word, the rest
// keep old_word.
// Ports: old_word (in), new_word (in), be (in), merged_c (out, comb).
module ram_byte_merge
  import ram_rmw_pkg::*;
(
  input  logic [RAM_WORD_W-1:0] old_word,
  input  logic [RAM_WORD_W-1:0] new_word,
  input  logic [RAM_BE_W-1:0]   be,
  output logic [RAM_WORD_W-1:0] merged_c
);

  for (genvar i = 0; i < RAM_BE_W; i++) begin : g_lane
    assign merged_c[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule

// File: rtl/ram_rmw_master.sv
// RAM read-modify-write master: turns byte-granular client requests into
// 64-bit one-cycle-latency RAM accesses; every write is a READ then a merged
// WRITE.
// Ports:
//   clock, reset_n (async, active-low)
//   bus (ram_rmw_master_if.master): req_* / rsp_* client handshake and
//       mem_* RAM pins.
// Parameter: MEM_DWORDS - RAM depth in 64-bit words; larger word indices
//   return rsp_err without touching the RAM.
// Build option: RAM_RMW_BYPASS_EN - full-word writes (be=8'hFF) skip the read.
// All outputs are registered; mem_* are decoded from the next state so they
// line up with the state they belong to.
module ram_rmw_master
  import ram_rmw_pkg::*;
#(
  parameter int unsigned MEM_DWORDS = RAM_MEMORY_SIZE_IN_DWORDS
) (
  input logic               clock,
  input logic               reset_n,
  ram_rmw_master_if.master  bus
);

  state_t                state;
  state_t                state_next;

  req_t                  req_in;
  req_t                  req_q;
  logic                  accept;
  logic                  in_range;

  logic [RAM_WORD_W-1:0] merged_c;
  logic [RAM_WORD_W-1:0] wbuf_q;
  logic [RAM_WORD_W-1:0] wbuf_next;
  logic [RAM_WIDX_W-1:0] widx_next;
  logic                  latch_req;
  logic                  err_set;
  logic                  cap_read;
  logic                  mem_active_next;

  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic [RAM_WORD_W-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic                  mem_ce_q;
  logic                  mem_we_q;
  logic [RAM_ADDR_W-1:0] mem_addr_q;
  logic [RAM_WORD_W-1:0] mem_din_q;

  // Byte offset bits carry no meaning for a word-wide RAM.
  logic                  unused_addr_lsb;
  assign unused_addr_lsb = ^bus.req_addr[RAM_LSB_W-1:0];

  assign req_in = '{
    write: bus.req_write,
    widx:  bus.req_addr[RAM_ADDR_W-1:RAM_LSB_W],
    wdata: bus.req_wdata,
    be:    bus.req_be
  };

  // req_ready_q is only high in IDLE (and not in the first cycle after reset).
  assign accept   = bus.req_valid & req_ready_q;
  assign in_range = req_in.widx < RAM_WIDX_W'(MEM_DWORDS);

  ram_byte_merge u_merge (
    .old_word (bus.mem_data_out),
    .new_word (req_q.wdata),
    .be       (req_q.be),
    .merged_c (merged_c)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus next values for the word index and write buffer.
  always_comb begin
    state_next = state;
    widx_next  = req_q.widx;
    wbuf_next  = wbuf_q;
    latch_req  = 1'b0;
    err_set    = 1'b0;
    cap_read   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          latch_req = 1'b1;
          widx_next = req_in.widx;
          if (!in_range) begin
            err_set    = 1'b1;
            state_next = RSP;
          end
`ifdef RAM_RMW_BYPASS_EN
          else if (req_in.write && (req_in.be == '1)) begin
            wbuf_next  = req_in.wdata;
            state_next = WR;
          end
`endif
          else begin
            state_next = RD;
          end
        end
      end
      RD: begin
        state_next = CAP;
      end
      CAP: begin
        if (req_q.write) begin
          wbuf_next  = merged_c;
          state_next = WR;
        end else begin
          cap_read   = 1'b1;
          state_next = RSP;
        end
      end
      WR: begin
        state_next = RSP;
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_active_next = (state_next == RD) || (state_next == WR);

  // Request latch, write buffer and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q       <= '0;
      wbuf_q      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      if (latch_req) begin
        req_q <= req_in;
      end
      wbuf_q      <= wbuf_next;
      req_ready_q <= (state_next == IDLE);
      rsp_valid_q <= (state_next == RSP);
      mem_ce_q    <= mem_active_next;
      mem_we_q    <= (state_next == WR);
      mem_addr_q  <= mem_active_next ? {widx_next, {RAM_LSB_W{1'b0}}} : '0;
      mem_din_q   <= (state_next == WR) ? wbuf_next : '0;

      if (err_set) begin
        rsp_err_q <= 1'b1;
      end else if ((state == RSP) && bus.rsp_ready) begin
        rsp_err_q <= 1'b0;
      end

      // Reads report the RAM word; writes report the word actually stored.
      if (cap_read) begin
        rsp_data_q <= bus.mem_data_out;
      end else if (state == WR) begin
        rsp_data_q <= wbuf_q;
      end
    end
  end

  assign bus.req_ready        = req_ready_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.mem_clock_enable = mem_ce_q;
  assign bus.mem_write_enab   = mem_we_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_data_in      = mem_din_q;

endmodule

// File: tb/tb_ram_rmw_master.sv
// Self-checking bench for ram_rmw_master: behavioural RAM, directed cases,
// randomized traffic and a scoreboard with an independent reference memory.
// Honours RAM_RMW_BYPASS_EN for the expected full-word write behaviour.
module tb_ram_rmw_master;
  import ram_rmw_pkg::*;

  localparam int unsigned MEM_DWORDS = RAM_MEMORY_SIZE_IN_DWORDS;
`ifdef RAM_RMW_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    bit          err;
    int          lat;
    int          ce_n;
    int          we_n;
  } exp_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ram_rmw_master_if bus ();

  ram_rmw_master #(.MEM_DWORDS(MEM_DWORDS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit [63:0] ram_arr [MEM_DWORDS];
  bit [63:0] ref_mem [MEM_DWORDS];
  exp_t      sb [$];
  exp_t      cur;
  bit        mon_en = 1'b0;
  bit        seen   = 1'b0;
  bit        pend   = 1'b0;
  int        acc_cyc, ce_cnt, we_cnt;
  int        rr_mode = 2;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: request semantics on a plain word array.
  function automatic exp_t model(bit wr, logic [35:0] addr, logic [63:0] wd, logic [7:0] be);
    exp_t        e;
    logic [32:0] w = addr[35:3];
    logic [63:0] old;
    bit          full;
    e.data = '0;
    e.err  = (w >= 33'(MEM_DWORDS));
    if (e.err) begin
      e.lat = 1; e.ce_n = 0; e.we_n = 0;
    end else if (!wr) begin
      e.data = ref_mem[w[14:0]];
      e.lat = 3; e.ce_n = 1; e.we_n = 0;
    end else begin
      old = ref_mem[w[14:0]];
      for (int b = 0; b < 8; b++) begin
        e.data[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
      end
      ref_mem[w[14:0]] = e.data;
      full   = BYPASS && (be == 8'hFF);
      e.lat  = full ? 2 : 4;
      e.ce_n = full ? 1 : 2;
      e.we_n = 1;
    end
    return e;
  endfunction

  // Behavioural RAM: one-cycle registered read, write on enabled edge.
  always @(posedge clock) begin
    if (bus.mem_clock_enable) begin
      if (bus.mem_write_enab) ram_arr[bus.mem_addr[17:3]] <= bus.mem_data_in;
      else                    bus.mem_data_out <= ram_arr[bus.mem_addr[17:3]];
    end
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Response-side handshake driver.
  always @(posedge clock) begin
    #1;
    case (rr_mode)
      0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
      1:       bus.rsp_ready = 1'b0;
      default: bus.rsp_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on each new response and polices the bus.
  always @(negedge clock) begin
    if (!mon_en) begin
      seen = 1'b0;
      pend = 1'b0;
    end else begin
      if (!bus.mem_clock_enable) begin
        check("idle_mem_write_enab", bus.mem_write_enab, 1'b0);
        check("idle_mem_data_in", bus.mem_data_in, 64'h0);
      end
      if (bus.rsp_valid) begin
        check("rsp_req_ready_low", bus.req_ready, 1'b0);
        check("rsp_mem_quiet", bus.mem_clock_enable, 1'b0);
        if (!seen) begin
          check("rsp_expected", sb.size() != 0, 1'b1);
          if (sb.size() != 0) begin
            cur  = sb.pop_front();
            seen = 1'b1;
            pend = 1'b0;
            check("rsp_latency", 64'(cyc - acc_cyc), 64'(cur.lat));
            check("rsp_err", bus.rsp_err, cur.err);
            if (!cur.err) check("rsp_data", bus.rsp_data, cur.data);
            check("mem_ce_cycles", 64'(ce_cnt), 64'(cur.ce_n));
            check("mem_we_cycles", 64'(we_cnt), 64'(cur.we_n));
          end
        end else begin
          check("stall_rsp_err", bus.rsp_err, cur.err);
          if (!cur.err) check("stall_rsp_data", bus.rsp_data, cur.data);
        end
        if (bus.rsp_ready) seen = 1'b0;
      end else if (pend) begin
        check("busy_req_ready_low", bus.req_ready, 1'b0);
        ce_cnt += int'(bus.mem_clock_enable);
        we_cnt += int'(bus.mem_write_enab);
      end
      if (bus.req_valid && bus.req_ready) begin
        pend    = 1'b1;
        acc_cyc = cyc;
        ce_cnt  = 0;
        we_cnt  = 0;
      end
    end
  end

  task automatic issue(bit wr, logic [35:0] addr, logic [63:0] wd, logic [7:0] be);
    int n = 0;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_be    = be;
    @(negedge clock);
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("req_accept", bus.req_ready, 1'b1);
    if (bus.req_ready) sb.push_back(model(wr, addr, wd, be));
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while ((sb.size() != 0 || !bus.req_ready) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(sb.size()), 64'h0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1'b0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_rsp_data"}, bus.rsp_data, 64'h0);
    check({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    check({tag, "_mem_ce"}, bus.mem_clock_enable, 1'b0);
    check({tag, "_mem_we"}, bus.mem_write_enab, 1'b0);
    check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'h0);
    check({tag, "_mem_din"}, bus.mem_data_in, 64'h0);
  endtask

  initial begin
    logic [63:0] v;
    logic [32:0] w;
    bit          wr;
    logic [7:0]  be;

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      v = {$urandom, $urandom};
      ram_arr[i] = v;
      ref_mem[i] = v;
    end
    ram_arr[5] = 64'h0123_4567_89AB_CDEF;
    ref_mem[5] = 64'h0123_4567_89AB_CDEF;

    // Reset values and registered req_ready rise.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    #2 reset_n = 1'b1;
    #1 check("ready_before_edge", bus.req_ready, 1'b0);
    @(posedge clock); #1;
    check("ready_after_edge", bus.req_ready, 1'b1);
    mon_en = 1'b1;

    // Directed cases.
    issue(1'b0, 36'h28, 64'h0, 8'h00);
    wait_idle("drain_read");
    issue(1'b1, 36'h28, 64'hFF, 8'h01);
    wait_idle("drain_partial");
    check("ram_word5_partial", ram_arr[5], 64'h0123_4567_89AB_CDFF);
    issue(1'b1, 36'h38, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    wait_idle("drain_full");
    check("ram_word7_full", ram_arr[7], 64'hDEAD_BEEF_0000_0001);
    issue(1'b1, 36'h48, 64'h1111_2222_3333_4444, 8'h00);
    issue(1'b0, 36'h4_0000, 64'h0, 8'h00);
    issue(1'b1, 36'h4_0008, 64'h5, 8'hFF);
    issue(1'b1, 36'h3_FFF8, 64'hA5A5_5A5A_0F0F_F0F0, 8'h3C);
    issue(1'b0, 36'h3_FFFF, 64'h0, 8'h00);
    wait_idle("drain_bounds");

    // Backpressure: response must hold with no memory traffic.
    rr_mode = 1;
    issue(1'b0, 36'h30, 64'h0, 8'h00);
    repeat (12) @(negedge clock);
    check("bp_rsp_valid_held", bus.rsp_valid, 1'b1);
    rr_mode = 2;
    issue(1'b1, 36'h30, 64'hCAFE_F00D_1234_5678, 8'hA5);
    wait_idle("drain_bp");

    // Randomized traffic with random response backpressure.
    rr_mode = 0;
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 9))
        0:       w = 33'(MEM_DWORDS) + 33'($urandom_range(0, 1000));
        1:       w = 33'(MEM_DWORDS - 1) - 33'($urandom_range(0, 3));
        default: w = 33'($urandom_range(0, 63));
      endcase
      wr = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 5))
        0:       be = 8'hFF;
        1:       be = 8'h00;
        default: be = 8'($urandom);
      endcase
      issue(wr, {w, 3'($urandom_range(0, 7))}, {$urandom, $urandom}, be);
    end
    rr_mode = 2;
    wait_idle("drain_random");

    // Reset during CAP of a partial write: nothing committed, no response.
    mon_en = 1'b0;
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 36'h28;
    bus.req_wdata = {$urandom, $urandom};
    bus.req_be    = 8'h0F;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    #1 check("ready_before_edge2", bus.req_ready, 1'b0);
    @(posedge clock); #1;
    check("ready_after_edge2", bus.req_ready, 1'b1);
    repeat (4) @(negedge clock);
    check("reset_word_unchanged", ram_arr[5], ref_mem[5]);
    check("reset_no_rsp", bus.rsp_valid, 1'b0);
    mon_en = 1'b1;
    issue(1'b0, 36'h28, 64'h0, 8'h00);
    wait_idle("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_rmw_master.md
# ram_rmw_master

Initiator-side controller for the main-memory RAM: turns byte-granular read/write requests into the 64-bit, one-cycle-latency read and write accesses the RAM accepts. Partial-word writes become a READ followed by a merged WRITE. The block sits between a client (CPU/DMA port) with a valid/ready request and response handshake and the RAM's `clock_enable`/`addr`/`write_enab`/`data_in`/`data_out` pins.

## Interface
- `MEM_DWORDS`, default 32768: RAM depth in 64-bit words (256 KiB); bounds the legal address range.
- `clock` in 1: single clock, shared with the RAM.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 36: byte address; bits [2:0] ignored.
- `req_wdata` in 64: write data, byte lanes aligned to the word.
- `req_be` in 8: byte enables; bit i covers `[8i+7:8i]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: client accepts the response.
- `rsp_data` out 64: read word (read) or final stored word (write).
- `rsp_err` out 1: address out of range, no memory access made.
- `mem_clock_enable` out 1: RAM clock enable.
- `mem_addr` out 36: RAM address, with bits [2:0] forced to 0.
- `mem_write_enab` out 1: RAM write enable.
- `mem_data_in` out 64: RAM write data.
- `mem_data_out` in 64: RAM registered read data.

## Operation
- States: `IDLE`, `RD`, `CAP`, `WR`, `RSP`.
- `IDLE`: `req_ready=1`. On `req_valid & req_ready`, latch `write`, `addr`, `wdata` and `be`.
  - If `addr[35:3] >= MEM_DWORDS`, set `rsp_err=1` and go to `RSP`.
  - Otherwise go to `RD`.
- `RD`: drive `mem_clock_enable=1`, `mem_write_enab=0`, `mem_addr=addr`. Next state is `CAP`.
- `CAP`: `mem_data_out` is valid.
  - Read: `rsp_data <= mem_data_out`, then go to `RSP`.
  - Write: `wbuf <= merge(mem_data_out, wdata, be)`, then go to `WR`.
  - A lane with `be[i]=1` takes `wdata`; a lane with `be[i]=0` keeps the old byte.
- `WR`: drive `mem_clock_enable=1`, `mem_write_enab=1`, `mem_addr=addr`, `mem_data_in=wbuf`. Set `rsp_data <= wbuf`, then go to `RSP`.
- `RSP`: `rsp_valid=1`; `rsp_data` and `rsp_err` are held stable. On `rsp_ready`, clear `rsp_err` and go to `IDLE`.
- Write with `be=8'h00`: the RAM is still read, and the unchanged word is written back. No special case.
- Outputs come only from `state` and the latched registers. There is no combinational path from `req_*` or `rsp_ready` to `mem_*`.
- Outside `RD` and `WR`: `mem_clock_enable=0`, `mem_write_enab=0`, `mem_data_in=0`.
- Exactly one request is in flight. `req_ready=0` in every state except `IDLE`.

## Timing
- Reset values: state `IDLE`, `req_ready=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, all `mem_*` = 0.
- `req_ready` is a registered flag. It rises on the first `clock` edge after `reset_n` is released.
- Latency from the accept edge T0 to `rsp_valid`:
  - Read: 3 cycles (RD@T1, CAP@T2, RSP@T3).
  - Partial write: 4 cycles (RD, CAP, WR, RSP@T4).
  - Out-of-range: 1 cycle.
- Back-to-back requests: the next accept is possible in the cycle after `rsp_valid & rsp_ready`. Throughput is at most one request per 4 or 5 cycles.
- `rsp_ready` held low stalls in `RSP` indefinitely with no memory activity.
- Reset mid-operation: all `mem_*` drop to 0 immediately.
  - A write is committed only if the `WR` cycle completed before `reset_n` fell.
  - Captured read data is discarded and no response is issued.

## Configuration
- `RAM_RMW_BYPASS_EN` defined: a write with `be=8'hFF` skips `RD`/`CAP`. `IDLE` goes to `WR` with `wbuf=wdata`; latency is 2 cycles.
- `RAM_RMW_BYPASS_EN` undefined: every write goes through `RD`/`CAP`. Behaviour and latency are identical for all byte-enable values.

## Structure
- Shared package `ram_rmw_pkg` holds:
  - the state enum;
  - the `RAM_MEMORY_SIZE_IN_DWORDS` constant (32768), used as the `MEM_DWORDS` default;
  - the `RAM_WORD_W=64` and `RAM_ADDR_W=36` constants.
- One sub-module: `ram_byte_merge`, the combinational 8-lane merge of old word, new word and byte enables, instantiated once.

## Test plan
- Read: RAM word 5 = `64'h0123_4567_89AB_CDEF`; read `addr=36'h28` -> `rsp_data` = that word at T0+3, `rsp_err=0`.
- Partial write: word 5 as above; write `be=8'h01`, `wdata=64'hFF` -> RAM word 5 = `64'h0123_4567_89AB_CDFF`, `rsp_data` matches, `mem_write_enab` high exactly 1 cycle.
- Full write: `be=8'hFF`, `wdata=64'hDEAD_BEEF_0000_0001`.
  - With `RAM_RMW_BYPASS_EN`: response at T0+2, no RD cycle.
  - Without it: response at T0+4.
- Out of range: read `addr=36'h4_0000` (word 32768) -> `rsp_err=1` at T0+1, `mem_clock_enable` never asserted.
- Backpressure: hold `rsp_ready=0` for 10 cycles -> `rsp_valid`, `rsp_data` and `rsp_err` stable, `req_ready=0`, no `mem_*` activity.
- Reset: assert `reset_n=0` during `CAP` of a partial write -> RAM word unchanged, all outputs 0 at once, `req_ready=1` one edge after release.
